// File: rtl/bitstream_loader.sv
// Autonomous fabric configuration writer: reads a byte-wide bitstream from a
// synchronous memory, packs bytes big-endian into words and strobes them out.
module bitstream_loader #(
   parameter int MAX_BYTES    = 16384,
   parameter int ADDR_W       = 14,
   parameter int SETUP_CYCLES = 2,
   parameter int HOLD_CYCLES  = 2
) (
   input  logic              CLK,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   byte_len,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [31:0]       SelfWriteData,
   output logic              SelfWriteStrobe,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-2:0] word_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   localparam logic [ADDR_W:0]   MAX_LEN    = (ADDR_W+1)'(MAX_BYTES);
   localparam logic [ADDR_W:0]   LEN_FOUR   = (ADDR_W+1)'(4);
   localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   LEN_ZERO   = (ADDR_W+1)'(0);
   localparam logic [ADDR_W-2:0] WC_ONE     = (ADDR_W-1)'(1);
   localparam logic [3:0]        SETUP_LAST = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0]        HOLD_LAST  = 4'(HOLD_CYCLES - 1);

   // Lane is 1-based in arrival order; lane 0 leaves the accumulator untouched.
   function automatic logic [31:0] put_lane(input logic [31:0] acc,
                                            input logic [2:0]  lane,
                                            input logic [7:0]  b);
      logic [31:0] r;
      r = acc;
      case (lane)
         3'd1:    r[31:24] = b;
         3'd2:    r[23:16] = b;
         3'd3:    r[15:8]  = b;
         3'd4:    r[7:0]   = b;
         default: r        = acc;
      endcase
      return r;
   endfunction

   state_t            state_r, state_next;
   logic [ADDR_W:0]   ptr_r, ptr_next;
   logic [ADDR_W:0]   rem_r, rem_next;
   logic [2:0]        k_r, k_next;
   logic [2:0]        fcnt_r, fcnt_next;
   logic [3:0]        cnt_r, cnt_next;
   logic [31:0]       acc_r, acc_next;
   logic              rd_en_r, rd_en_next;
   logic [ADDR_W-1:0] addr_r, addr_next;
   logic [31:0]       data_r, data_next;
   logic              strobe_r, strobe_next;
   logic              busy_r, busy_next;
   logic              done_r, done_next;
   logic [ADDR_W-2:0] wcnt_r, wcnt_next;

   logic              go_fetch_s;
   logic [ADDR_W:0]   fetch_rem_s;
   logic [ADDR_W:0]   fetch_ptr_s;
   logic [ADDR_W:0]   len_s;
   logic [31:0]       word_s;

   // Next-state and next-output computation; all outputs leave through registers.
   always_comb begin
      state_next  = state_r;
      ptr_next    = ptr_r;
      rem_next    = rem_r;
      k_next      = k_r;
      fcnt_next   = fcnt_r;
      cnt_next    = cnt_r;
      acc_next    = acc_r;
      rd_en_next  = 1'b0;
      addr_next   = addr_r;
      data_next   = data_r;
      strobe_next = 1'b0;
      busy_next   = busy_r;
      done_next   = done_r;
      wcnt_next   = wcnt_r;
      go_fetch_s  = 1'b0;
      fetch_rem_s = rem_r;
      fetch_ptr_s = ptr_r;
      len_s       = (byte_len > MAX_LEN) ? MAX_LEN : byte_len;
      word_s      = put_lane(acc_r, fcnt_r, mem_rdata);

      case (state_r)
         S_IDLE: begin
            if (start) begin
               busy_next = 1'b1;
               done_next = 1'b0;
               wcnt_next = '0;
               if (len_s == LEN_ZERO) begin
                  state_next = S_FINISH;
               end else begin
                  go_fetch_s  = 1'b1;
                  fetch_rem_s = len_s;
                  fetch_ptr_s = LEN_ZERO;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_FETCH: begin
            // fcnt_r counts cycles in FETCH; data of read j lands in cycle j+1.
            acc_next = word_s;
            if (fcnt_r == k_r) begin
               data_next  = word_s;
               state_next = S_SETUP;
               cnt_next   = 4'd0;
            end else begin
               fcnt_next = fcnt_r + 3'd1;
               if ((fcnt_r + 3'd1) < k_r) begin
                  rd_en_next = 1'b1;
                  addr_next  = ptr_r[ADDR_W-1:0];
                  ptr_next   = ptr_r + LEN_ONE;
                  rem_next   = rem_r - LEN_ONE;
               end else begin
                  rd_en_next = 1'b0;
               end
            end
         end
         S_SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               state_next  = S_STROBE;
               strobe_next = 1'b1;
               wcnt_next   = wcnt_r + WC_ONE;
            end else begin
               cnt_next = cnt_r + 4'd1;
            end
         end
         S_STROBE: begin
            cnt_next = 4'd0;
            if (HOLD_CYCLES == 0) begin
               if (rem_r != LEN_ZERO) begin
                  go_fetch_s = 1'b1;
               end else begin
                  state_next = S_FINISH;
               end
            end else begin
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_r == HOLD_LAST) begin
               if (rem_r != LEN_ZERO) begin
                  go_fetch_s = 1'b1;
               end else begin
                  state_next = S_FINISH;
               end
            end else begin
               cnt_next = cnt_r + 4'd1;
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if (go_fetch_s) begin
         state_next = S_FETCH;
         fcnt_next  = 3'd0;
         acc_next   = 32'h0000_0000;
         k_next     = (fetch_rem_s >= LEN_FOUR) ? 3'd4 : fetch_rem_s[2:0];
         rd_en_next = 1'b1;
         addr_next  = fetch_ptr_s[ADDR_W-1:0];
         ptr_next   = fetch_ptr_s + LEN_ONE;
         rem_next   = fetch_rem_s - LEN_ONE;
      end else begin
         k_next = k_next;
      end

      // Abort wins over everything, including a coincident start in IDLE.
      if (abort) begin
         state_next  = S_IDLE;
         rd_en_next  = 1'b0;
         strobe_next = 1'b0;
         busy_next   = 1'b0;
         done_next   = done_r;
         wcnt_next   = wcnt_r;
         data_next   = data_r;
      end else begin
         state_next = state_next;
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_r  <= S_IDLE;
         ptr_r    <= '0;
         rem_r    <= '0;
         k_r      <= 3'd0;
         fcnt_r   <= 3'd0;
         cnt_r    <= 4'd0;
         acc_r    <= 32'h0000_0000;
         rd_en_r  <= 1'b0;
         addr_r   <= '0;
         data_r   <= 32'h0000_0000;
         strobe_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         wcnt_r   <= '0;
      end else begin
         state_r  <= state_next;
         ptr_r    <= ptr_next;
         rem_r    <= rem_next;
         k_r      <= k_next;
         fcnt_r   <= fcnt_next;
         cnt_r    <= cnt_next;
         acc_r    <= acc_next;
         rd_en_r  <= rd_en_next;
         addr_r   <= addr_next;
         data_r   <= data_next;
         strobe_r <= strobe_next;
         busy_r   <= busy_next;
         done_r   <= done_next;
         wcnt_r   <= wcnt_next;
      end
   end

   assign mem_rd_en       = rd_en_r;
   assign mem_addr        = addr_r;
   assign SelfWriteData   = data_r;
   assign SelfWriteStrobe = strobe_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign word_count      = wcnt_r;

endmodule
